// File: rtl/onewire_slave_core.sv
// 1-Wire slave engine: bus reset/presence, ROM layer (READ, SKIP, MATCH,
// SEARCH) and scratchpad function layer (WRITE/READ SCRATCHPAD).
// All bus timing is derived from TICKS_PER_US.
module onewire_slave_core #(
  parameter int TICKS_PER_US = 10,
  parameter int SPAD_BYTES   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_slave,
  input  logic                    bus,
  output logic                    slave_pull_low,
  input  logic [63:0]             rom_id,
  input  logic [8*SPAD_BYTES-1:0] spad_in,
  output logic [8*SPAD_BYTES-1:0] spad_out,
  output logic                    spad_wr_done,
  output logic                    selected
);

  localparam int RST_MIN   = 480 * TICKS_PER_US;
  localparam int PRES_WAIT = 30 * TICKS_PER_US;
  localparam int PRES_LEN  = 120 * TICKS_PER_US;
  localparam int SAMPLE    = 30 * TICKS_PER_US;
  localparam int TX0_LEN   = 30 * TICKS_PER_US;
  localparam int SPAD_BITS = 8 * SPAD_BYTES;
  localparam int LCW = ($clog2(RST_MIN + 1) > 16) ? $clog2(RST_MIN + 1) : 16;
  localparam int CW  = $clog2(PRES_LEN + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRES_WAIT, S_PRES, S_ROM_CMD, S_ROM_TX,
    S_ROM_MATCH, S_SEARCH, S_FN_CMD, S_FN_WR, S_FN_RD
  } state_e;

  logic                 bus_s1_q, bus_s2_q, bus_s3_q;
  logic [LCW-1:0]       low_cnt_q, low_cnt_d;
  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 slot_act_q;
  logic [8:0]           idx_q;
  logic [1:0]           phase_q;
  logic [6:0]           shift_q;
  logic [SPAD_BITS-1:0] rd_sh_q, spad_q;
  logic                 pull_q, wr_done_q, sel_q;

  logic       fall_w, rise_w, rst_hit, tx_mode, tx_bit, slot_done;
  logic [7:0] rx_byte;

  // Two-flop synchroniser plus one history flop for edge detection; idles high.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_s1_q <= 1'b1;
      bus_s2_q <= 1'b1;
      bus_s3_q <= 1'b1;
    end else begin
      bus_s1_q <= bus;
      bus_s2_q <= bus_s1_q;
      bus_s3_q <= bus_s2_q;
    end
  end

  assign fall_w  = bus_s3_q & ~bus_s2_q;
  assign rise_w  = ~bus_s3_q & bus_s2_q;
  assign rx_byte = {bus_s2_q, shift_q};

  // Saturating low-time counter; cycles spent under our own pull are not counted.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    low_cnt_d = low_cnt_q;
    if (!en_slave || bus_s2_q) begin
      low_cnt_d = '0;
    end else if (!pull_q && (low_cnt_q != {LCW{1'b1}})) begin
      low_cnt_d = low_cnt_q + LCW'(1);
    end
  end

  // Low-time counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) low_cnt_q <= '0;
    else        low_cnt_q <= low_cnt_d;
  end

  assign rst_hit = rise_w && (low_cnt_q >= LCW'(RST_MIN));

  // Which bit (if any) the current slot transmits.
  always_comb begin
    tx_mode = 1'b0;
    tx_bit  = 1'b1;
    case (state_q)
      S_ROM_TX: begin
        tx_mode = 1'b1;
        tx_bit  = rom_id[idx_q[5:0]];
      end
      S_SEARCH: begin
        tx_mode = (phase_q != 2'd2);
        tx_bit  = phase_q[0] ? ~rom_id[idx_q[5:0]] : rom_id[idx_q[5:0]];
      end
      S_FN_RD: begin
        tx_mode = 1'b1;
        tx_bit  = rd_sh_q[0];
      end
      default: ;
    endcase
  end

  assign slot_done = slot_act_q &&
                     (cnt_q == (tx_mode ? CW'(TX0_LEN - 1) : CW'(SAMPLE - 1)));

  // Protocol FSM: presence, bit slots, ROM and function layers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      slot_act_q <= 1'b0;
      idx_q      <= '0;
      phase_q    <= '0;
      shift_q    <= '0;
      rd_sh_q    <= '0;
      // NOTE: the scratchpad is reset because its power-up content is visible on spad_out.
      spad_q     <= '0;
      pull_q     <= 1'b0;
      wr_done_q  <= 1'b0;
      sel_q      <= 1'b0;
    end else if (!en_slave) begin
      state_q    <= S_IDLE;
      slot_act_q <= 1'b0;
      pull_q     <= 1'b0;
      wr_done_q  <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      if (rst_hit) begin
        state_q    <= S_PRES_WAIT;
        cnt_q      <= '0;
        slot_act_q <= 1'b0;
        idx_q      <= '0;
        phase_q    <= '0;
        pull_q     <= 1'b0;
        sel_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_PRES_WAIT: begin
            if (cnt_q == CW'(PRES_WAIT - 1)) begin
              state_q <= S_PRES;
              pull_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_PRES: begin
            if (cnt_q == CW'(PRES_LEN - 1)) begin
              state_q <= S_ROM_CMD;
              pull_q  <= 1'b0;
              cnt_q   <= '0;
              idx_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            if (fall_w) begin
              // A new fall always (re)starts the slot; an unfinished one is dropped.
              slot_act_q <= 1'b1;
              cnt_q      <= '0;
              pull_q     <= tx_mode & ~tx_bit;
            end else if (slot_done) begin
              slot_act_q <= 1'b0;
              pull_q     <= 1'b0;
              case (state_q)
                S_ROM_CMD: begin
                  shift_q <= rx_byte[7:1];
                  idx_q   <= idx_q + 9'd1;
                  if (idx_q == 9'd7) begin
                    idx_q   <= '0;
                    phase_q <= '0;
                    case (rx_byte)
                      8'h33:   state_q <= S_ROM_TX;
                      8'hCC: begin
                        sel_q   <= 1'b1;
                        state_q <= S_FN_CMD;
                      end
                      8'h55:   state_q <= S_ROM_MATCH;
                      8'hF0:   state_q <= S_SEARCH;
                      default: state_q <= S_IDLE;
                    endcase
                  end
                end
                S_ROM_TX, S_ROM_MATCH: begin
                  idx_q <= idx_q + 9'd1;
                  if (state_q == S_ROM_MATCH && bus_s2_q != rom_id[idx_q[5:0]]) begin
                    state_q <= S_IDLE;
                  end else if (idx_q == 9'd63) begin
                    idx_q   <= '0;
                    sel_q   <= 1'b1;
                    state_q <= S_FN_CMD;
                  end
                end
                S_SEARCH: begin
                  if (phase_q != 2'd2) begin
                    phase_q <= phase_q + 2'd1;
                  end else if (bus_s2_q != rom_id[idx_q[5:0]]) begin
                    state_q <= S_IDLE;
                  end else if (idx_q == 9'd63) begin
                    idx_q   <= '0;
                    sel_q   <= 1'b1;
                    state_q <= S_FN_CMD;
                  end else begin
                    idx_q   <= idx_q + 9'd1;
                    phase_q <= '0;
                  end
                end
                S_FN_CMD: begin
                  shift_q <= rx_byte[7:1];
                  idx_q   <= idx_q + 9'd1;
                  if (idx_q == 9'd7) begin
                    idx_q <= '0;
                    case (rx_byte)
                      8'h4E:   state_q <= S_FN_WR;
                      8'hBE: begin
                        rd_sh_q <= spad_in;
                        state_q <= S_FN_RD;
                      end
                      default: state_q <= S_IDLE;
                    endcase
                  end
                end
                S_FN_WR: begin
                  shift_q <= rx_byte[7:1];
                  idx_q   <= idx_q + 9'd1;
                  if (idx_q[2:0] == 3'd7) begin
                    for (int b = 0; b < SPAD_BYTES; b++) begin
                      if (idx_q[8:3] == 6'(b)) spad_q[b*8 +: 8] <= rx_byte;
                    end
                  end
                  if (idx_q == 9'(SPAD_BITS - 1)) begin
                    wr_done_q <= 1'b1;
                    state_q   <= S_IDLE;
                  end
                end
                S_FN_RD: begin
                  rd_sh_q <= rd_sh_q >> 1;
                  idx_q   <= idx_q + 9'd1;
                  if (idx_q == 9'(SPAD_BITS - 1)) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
              endcase
            end else if (slot_act_q) begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        endcase
      end
    end
  end

  assign slave_pull_low = pull_q;
  assign spad_out       = spad_q;
  assign spad_wr_done   = wr_done_q;
  assign selected       = sel_q;

endmodule

// File: tb/tb_onewire_slave_core.sv
// Directed bench for onewire_slave_core acting as a 1-Wire bus master.
module tb_onewire_slave_core;

  localparam int T         = 2;
  localparam int SPB       = 2;
  localparam int RST_MIN_C = 480 * T;
  localparam int PWAIT_C   = 30 * T;
  localparam int PLEN_C    = 120 * T;
  localparam int SAMPLE_C  = 30 * T;
  localparam int SLOT      = SAMPLE_C + 20;
  localparam int W0_LOW    = SAMPLE_C + 10;
  localparam int W1_LOW    = 4;
  localparam int RD_LOW    = 4;
  localparam int RD_SAMPLE = SAMPLE_C / 2;

  typedef struct { int low_cyc; logic pres; } pres_vec_t;
  typedef struct { logic [15:0] wr; logic [15:0] rd; } spad_vec_t;

  logic        clk = 1'b0;
  logic        rst_n, en, m_low;
  logic [63:0] rom;
  logic [15:0] spad_in_t, spad_out_w;
  logic        pull_w, done_w, sel_w;
  wire         bus_w = ~(m_low | pull_w);

  int total = 0;
  int bad   = 0;
  int done_cycles = 0;
  logic [15:0] spad_at_done = '0;

  onewire_slave_core #(.TICKS_PER_US(T), .SPAD_BYTES(SPB)) dut (
    .clk(clk), .reset(rst_n), .en_slave(en), .bus(bus_w),
    .slave_pull_low(pull_w), .rom_id(rom), .spad_in(spad_in_t),
    .spad_out(spad_out_w), .spad_wr_done(done_w), .selected(sel_w)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_w) begin
      done_cycles  = done_cycles + 1;
      spad_at_done = spad_out_w;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_reset(input int low_cyc, input logic exp_pres, input string nm);
    int d = 0;
    int w = 0;
    logic seen = 1'b0;
    m_low = 1'b1;
    tick(low_cyc);
    m_low = 1'b0;
    while (d < PWAIT_C + 200 && !seen) begin
      tick(1);
      d++;
      if (pull_w) seen = 1'b1;
    end
    check({nm, "_presence"}, seen, exp_pres);
    if (seen) begin
      check({nm, "_pres_delay"}, (d >= PWAIT_C + 2) && (d <= PWAIT_C + 4), 1'b1);
      while (pull_w && w < PLEN_C + 50) begin
        w++;
        tick(1);
      end
      check({nm, "_pres_width"}, w, PLEN_C);
    end
    tick(20);
  endtask

  task automatic wr_bit(input logic b);
    int lo = b ? W1_LOW : W0_LOW;
    m_low = 1'b1;
    tick(lo);
    m_low = 1'b0;
    tick(SLOT - lo);
  endtask

  task automatic rd_bit(output logic b, output logic pulled);
    b = 1'bx;
    pulled = 1'b0;
    m_low = 1'b1;
    for (int i = 0; i < SLOT; i++) begin
      if (i == RD_LOW) m_low = 1'b0;
      if (i == RD_SAMPLE) b = bus_w;
      tick(1);
      pulled = pulled | pull_w;
    end
  endtask

  task automatic wr_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) wr_bit(v[i]);
  endtask

  task automatic rd_byte(output logic [7:0] v, output int pulls);
    logic b, p;
    pulls = 0;
    for (int i = 0; i < 8; i++) begin
      rd_bit(b, p);
      v[i] = b;
      if (p) pulls++;
    end
  endtask

  initial begin
    pres_vec_t pv[4];
    spad_vec_t sv[2];
    logic [63:0] got;
    logic [15:0] rdw;
    logic [7:0]  lo_b, hi_b;
    logic        b0, b1, p0, p1;
    int errs, pulls, pulls2, dc0, wt;

    pv[0] = '{800, 1'b0};
    pv[1] = '{RST_MIN_C - 1, 1'b0};
    pv[2] = '{RST_MIN_C, 1'b1};
    pv[3] = '{1000, 1'b1};
    sv[0] = '{16'hC35A, 16'h81FF};
    sv[1] = '{16'h0F3C, 16'h7E01};

    rst_n = 1'b0; en = 1'b1; m_low = 1'b0;
    rom = 64'hA200_0001_2345_6728;
    spad_in_t = '0;
    tick(3);
    check("rst_pull", pull_w, 1'b0);
    check("rst_spad_out", spad_out_w, 16'h0);
    check("rst_wr_done", done_w, 1'b0);
    check("rst_selected", sel_w, 1'b0);
    rst_n = 1'b1;
    tick(5);

    // Reset-pulse length against the presence threshold.
    for (int i = 0; i < 4; i++) begin
      bus_reset(pv[i].low_cyc, pv[i].pres, $sformatf("pres_vec%0d", i));
    end

    // READ ROM: bits LSB first, pull only on zero bits.
    bus_reset(1000, 1'b1, "rd_rom");
    wr_byte(8'h33);
    check("rd_rom_sel_before", sel_w, 1'b0);
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      rd_bit(b0, p0);
      got[i] = b0;
      if (p0 !== ~rom[i]) errs++;
    end
    check("rd_rom_data", got, rom);
    check("rd_rom_pull_pattern", errs, 0);
    check("rd_rom_selected", sel_w, 1'b1);

    // MATCH ROM with bit 5 wrong: slave goes silent, READ SCRATCHPAD ignored.
    bus_reset(1000, 1'b1, "match");
    check("match_sel_cleared", sel_w, 1'b0);
    wr_byte(8'h55);
    for (int i = 0; i < 8; i++) wr_bit((i == 5) ? ~rom[i] : rom[i]);
    wr_byte(8'hBE);
    rd_byte(lo_b, pulls);
    rd_byte(hi_b, pulls2);
    check("match_fail_read", {hi_b, lo_b}, 16'hFFFF);
    check("match_fail_pulls", pulls + pulls2, 0);
    check("match_fail_selected", sel_w, 1'b0);

    // SEARCH ROM, correct directions for all 64 bits.
    bus_reset(1000, 1'b1, "search");
    wr_byte(8'hF0);
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      rd_bit(b0, p0);
      rd_bit(b1, p1);
      if (b0 !== rom[i] || b1 !== ~rom[i]) errs++;
      wr_bit(rom[i]);
    end
    check("search_pairs", errs, 0);
    check("search_selected", sel_w, 1'b1);

    // SEARCH ROM, wrong direction at bit 10: silent afterwards.
    bus_reset(1000, 1'b1, "search_bad");
    check("search_bad_sel_cleared", sel_w, 1'b0);
    wr_byte(8'hF0);
    errs = 0;
    for (int i = 0; i <= 10; i++) begin
      rd_bit(b0, p0);
      rd_bit(b1, p1);
      if (b0 !== rom[i] || b1 !== ~rom[i]) errs++;
      wr_bit((i == 10) ? ~rom[i] : rom[i]);
    end
    check("search_bad_pairs", errs, 0);
    pulls = 0;
    for (int i = 0; i < 3; i++) begin
      rd_bit(b0, p0);
      if (p0 || b0 !== 1'b1) pulls++;
    end
    check("search_bad_silent", pulls, 0);
    check("search_bad_selected", sel_w, 1'b0);

    // Scratchpad write then read-back of an independent source word.
    for (int v = 0; v < 2; v++) begin
      bus_reset(1000, 1'b1, $sformatf("spad_wr%0d", v));
      wr_byte(8'hCC);
      check($sformatf("spad%0d_skip_sel", v), sel_w, 1'b1);
      wr_byte(8'h4E);
      dc0 = done_cycles;
      wr_byte(sv[v].wr[7:0]);
      wr_byte(sv[v].wr[15:8]);
      tick(4);
      check($sformatf("spad%0d_out", v), spad_out_w, sv[v].wr);
      check($sformatf("spad%0d_done_cycles", v), done_cycles - dc0, 1);
      check($sformatf("spad%0d_out_at_done", v), spad_at_done, sv[v].wr);

      bus_reset(1000, 1'b1, $sformatf("spad_rd%0d", v));
      wr_byte(8'hCC);
      spad_in_t = sv[v].rd;
      wr_byte(8'hBE);
      spad_in_t = ~sv[v].rd;
      rd_byte(lo_b, pulls);
      rd_byte(hi_b, pulls2);
      rdw = {hi_b, lo_b};
      check($sformatf("spad%0d_read", v), rdw, sv[v].rd);
    end

    // Bus reset after the first WRITE byte keeps byte 0 only.
    bus_reset(1000, 1'b1, "partial");
    wr_byte(8'hCC);
    wr_byte(8'h4E);
    dc0 = done_cycles;
    wr_byte(8'h11);
    bus_reset(1000, 1'b1, "partial_abort");
    check("partial_spad_out", spad_out_w, {sv[1].wr[15:8], 8'h11});
    check("partial_no_done", done_cycles - dc0, 0);

    // Disabling the core during presence releases the bus.
    m_low = 1'b1;
    tick(1000);
    m_low = 1'b0;
    wt = 0;
    while (!pull_w && wt < 200) begin
      tick(1);
      wt++;
    end
    check("en_pres_seen", pull_w, 1'b1);
    en = 1'b0;
    tick(1);
    check("en_low_pull", pull_w, 1'b0);
    check("en_low_selected", sel_w, 1'b0);
    check("en_low_spad_kept", spad_out_w, {sv[1].wr[15:8], 8'h11});
    en = 1'b1;
    tick(20);

    // Asynchronous reset in the middle of the presence pull.
    m_low = 1'b1;
    tick(1000);
    m_low = 1'b0;
    wt = 0;
    while (!pull_w && wt < 200) begin
      tick(1);
      wt++;
    end
    check("arst_pres_seen", pull_w, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_pull_released", pull_w, 1'b0);
    check("arst_spad_cleared", spad_out_w, 16'h0);
    rst_n = 1'b1;
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
